// File: rtl/uart_frame_pkg.sv
// Shared definitions for the player position frame receiver.
// Sync byte, frame FSM states and coordinate width.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         COORD_W   = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_X_HI,
    S_X_LO,
    S_Y_HI,
    S_Y_LO,
    S_FLG,
    S_CHK
  } frame_state_e;

endpackage

// File: rtl/player_frame_rx_if.sv
// Byte stream from the UART receive path into the frame receiver.
// The master drives bytes; the slave consumes them.
interface player_frame_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/frame_timer.sv
// Inter-byte timeout and link-alive counters for the frame receiver.
// The link counter presets to its limit so the link starts down.
module frame_timer #(
  parameter int BYTE_TIMEOUT = 20000,
  parameter int LINK_TIMEOUT = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic byte_seen,
  input  logic good_frame,
  output logic byte_to,
  output logic link_up
);

  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [BW-1:0] BMAX = BW'(BYTE_TIMEOUT);
  localparam logic [LW-1:0] LMAX = LW'(LINK_TIMEOUT);

  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [LW-1:0] link_cnt_q, link_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (byte_seen || !busy) begin
      byte_cnt_d = '0;
    end else if (byte_cnt_q != BMAX) begin
      byte_cnt_d = byte_cnt_q + BW'(1);
    end
    link_cnt_d = link_cnt_q;
    if (good_frame) begin
      link_cnt_d = '0;
    end else if (link_cnt_q != LMAX) begin
      link_cnt_d = link_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      link_cnt_q <= LMAX;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      link_cnt_q <= link_cnt_d;
    end
  end

  assign byte_to = busy && (byte_cnt_q == BMAX);
  assign link_up = (link_cnt_q < LMAX);

endmodule

// File: rtl/player_frame_rx.sv
// Receives 7-byte player frames, checks range and XOR checksum,
// and commits position/flags atomically on a good frame.
module player_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 20000,
  parameter int LINK_TIMEOUT = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  player_frame_rx_if.slave   rx,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [7:0]         flags,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               link_up
);

  frame_state_e state_q, state_d;
  logic [7:0] xor_q, xor_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [7:0] flg_q, flg_d;
  logic rng_q, rng_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [7:0] flags_q, flags_d;
  logic fv_q, fv_d, fe_q, fe_d;
  logic byte_to;

  frame_timer #(
    .BYTE_TIMEOUT(BYTE_TIMEOUT),
    .LINK_TIMEOUT(LINK_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .busy      (state_q != S_IDLE),
    .byte_seen (rx.rx_valid),
    .good_frame(fv_q),
    .byte_to   (byte_to),
    .link_up   (link_up)
  );

  always_comb begin
    state_d = state_q;
    xor_d   = xor_q;
    x_d     = x_q;
    y_d     = y_q;
    flg_d   = flg_q;
    rng_d   = rng_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    flags_d = flags_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    // An arriving byte takes priority over a coincident timeout
    if (rx.rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx.rx_data == SYNC_BYTE) begin
            state_d = S_X_HI;
            xor_d   = '0;
            rng_d   = 1'b0;
          end
        end
        S_X_HI: begin
          x_d[COORD_W-1:8] = rx.rx_data[3:0];
          rng_d   = rng_q | (|rx.rx_data[7:4]);
          xor_d   = xor_q ^ rx.rx_data;
          state_d = S_X_LO;
        end
        S_X_LO: begin
          x_d[7:0] = rx.rx_data;
          xor_d    = xor_q ^ rx.rx_data;
          state_d  = S_Y_HI;
        end
        S_Y_HI: begin
          y_d[COORD_W-1:8] = rx.rx_data[3:0];
          rng_d   = rng_q | (|rx.rx_data[7:4]);
          xor_d   = xor_q ^ rx.rx_data;
          state_d = S_Y_LO;
        end
        S_Y_LO: begin
          y_d[7:0] = rx.rx_data;
          xor_d    = xor_q ^ rx.rx_data;
          state_d  = S_FLG;
        end
        S_FLG: begin
          flg_d   = rx.rx_data;
          xor_d   = xor_q ^ rx.rx_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (xor_q == rx.rx_data && !rng_q) begin
            pos_x_d = x_q;
            pos_y_d = y_q;
            flags_d = flg_q;
            fv_d    = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (byte_to) begin
      state_d = S_IDLE;
      fe_d    = 1'b1;
      xor_d   = '0;
      rng_d   = 1'b0;
      x_d     = '0;
      y_d     = '0;
      flg_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      xor_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      flg_q   <= '0;
      rng_q   <= 1'b0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      flags_q <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xor_q   <= xor_d;
      x_q     <= x_d;
      y_q     <= y_d;
      flg_q   <= flg_d;
      rng_q   <= rng_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      flags_q <= flags_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign flags       = flags_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_player_frame_rx.sv
// Scoreboard bench for player_frame_rx: expected frame events are
// queued at stimulus time and matched against observed pulses.
module tb_player_frame_rx;

  localparam int BT = 16;
  localparam int LT = 200;

  typedef struct packed {
    logic        fv;
    logic        fe;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  f;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] pos_x, pos_y;
  logic [7:0]  flags;
  logic frame_valid, frame_err, link_up;

  player_frame_rx_if rx_if ();

  player_frame_rx #(
    .BYTE_TIMEOUT(BT),
    .LINK_TIMEOUT(LT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_if),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .flags      (flags),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .link_up    (link_up)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [11:0] cur_x = '0;
  logic [11:0] cur_y = '0;
  logic [7:0]  cur_f = '0;
  ev_t e, o;

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err))
      obs_q.push_back({frame_valid, frame_err, pos_x, pos_y, flags});
  end

  function automatic logic [7:0] calc_chk(input logic [7:0] a, b, c, d, f);
    return a ^ b ^ c ^ d ^ f;
  endfunction

  // Called at a negedge; byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] xh, xl, yh, yl, fl, ck,
                            input int gap);
    send_byte(8'hA5, gap);
    send_byte(xh, gap);
    send_byte(xl, gap);
    send_byte(yh, gap);
    send_byte(yl, gap);
    send_byte(fl, gap);
    send_byte(ck, 0);
  endtask

  task automatic push_good(input logic [11:0] x, y, input logic [7:0] f);
    cur_x = x;
    cur_y = y;
    cur_f = f;
    exp_q.push_back({1'b1, 1'b0, x, y, f});
  endtask

  task automatic push_err();
    exp_q.push_back({1'b0, 1'b1, cur_x, cur_y, cur_f});
  endtask

  task automatic test_reset();
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pos_x !== 12'h0 || pos_y !== 12'h0 || flags !== 8'h0) begin
      errors++;
      $display("FAIL reset_pos got=%h/%h/%h exp=0/0/0", pos_x, pos_y, flags);
    end
    checks++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse got fv=%b fe=%b exp 0/0", frame_valid, frame_err);
    end
    checks++;
    if (link_up !== 1'b0) begin
      errors++;
      $display("FAIL reset_link got=%b exp=0", link_up);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] ck;
    ck = calc_chk(8'h01, 8'h23, 8'h02, 8'h34, 8'h05);
    push_good(12'h123, 12'h234, 8'h05);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 1);
    send_byte(8'h23, 0);
    send_byte(8'h02, 2);
    send_byte(8'h34, 0);
    send_byte(8'h05, 0);
    checks++;
    if (pos_x !== 12'h000 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_commit got pos_x=%h fv=%b exp 000/0", pos_x, frame_valid);
    end
    send_byte(ck, 0);
    checks++;
    if (frame_valid !== 1'b1 || pos_x !== 12'h123) begin
      errors++;
      $display("FAIL commit_latency got fv=%b pos_x=%h exp 1/123", frame_valid, pos_x);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (link_up !== 1'b1) begin
      errors++;
      $display("FAIL link_up_rise got=%b exp=1", link_up);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL good_frame missing event exp=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL good_frame event got=%h exp=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL good_frame extra events got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_bad_frames();
    push_err();
    send_frame(8'h01, 8'h23, 8'h02, 8'h34, 8'h05, 8'h14, 0);
    push_err();
    send_frame(8'h11, 8'h23, 8'h02, 8'h34, 8'h05,
               calc_chk(8'h11, 8'h23, 8'h02, 8'h34, 8'h05), 1);
    push_err();
    send_frame(8'h01, 8'h23, 8'hF2, 8'h34, 8'h05,
               calc_chk(8'h01, 8'h23, 8'hF2, 8'h34, 8'h05), 0);
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL bad_frame missing event exp=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL bad_frame event got=%h exp=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bad_frame extra events got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    push_err();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    repeat (BT + 4) @(negedge clk);
    push_good(12'h456, 12'h789, 8'h3C);
    send_frame(8'h04, 8'h56, 8'h07, 8'h89, 8'h3C,
               calc_chk(8'h04, 8'h56, 8'h07, 8'h89, 8'h3C), 0);
    // byte arriving exactly as the counter hits the limit is accepted
    push_good(12'h0AB, 12'h0CD, 8'h81);
    send_frame(8'h00, 8'hAB, 8'h00, 8'hCD, 8'h81,
               calc_chk(8'h00, 8'hAB, 8'h00, 8'hCD, 8'h81), BT);
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL timeout missing event exp=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL timeout event got=%h exp=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL timeout extra events got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_garbage_and_b2b();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h7E, 2);
    push_good(12'hAA5, 12'hBA5, 8'hA5);
    send_frame(8'h0A, 8'hA5, 8'h0B, 8'hA5, 8'hA5,
               calc_chk(8'h0A, 8'hA5, 8'h0B, 8'hA5, 8'hA5), 0);
    push_good(12'h321, 12'h654, 8'h07);
    send_frame(8'h03, 8'h21, 8'h06, 8'h54, 8'h07,
               calc_chk(8'h03, 8'h21, 8'h06, 8'h54, 8'h07), 0);
    push_good(12'hFFF, 12'h000, 8'hFF);
    send_frame(8'h0F, 8'hFF, 8'h00, 8'h00, 8'hFF,
               calc_chk(8'h0F, 8'hFF, 8'h00, 8'h00, 8'hFF), 0);
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b missing event exp=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b event got=%h exp=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL b2b extra events got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_link_timeout();
    int n;
    push_good(12'h111, 12'h222, 8'h33);
    send_frame(8'h01, 8'h11, 8'h02, 8'h22, 8'h33,
               calc_chk(8'h01, 8'h11, 8'h02, 8'h22, 8'h33), 0);
    n = 0;
    for (int i = 1; i <= LT + 10; i++) begin
      @(negedge clk);
      if (!link_up) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != LT + 1) begin
      errors++;
      $display("FAIL link_drop got cycles=%0d exp=%0d", n, LT + 1);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL link_frame got events=%0d exp=1", obs_q.size());
      obs_q.delete();
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL link_frame event got=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h33, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cur_x = '0;
    cur_y = '0;
    cur_f = '0;
    checks++;
    if (pos_x !== 12'h0 || pos_y !== 12'h0 || flags !== 8'h0 ||
        frame_valid !== 1'b0 || frame_err !== 1'b0 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got=%h/%h/%h fv=%b fe=%b lu=%b exp all 0",
               pos_x, pos_y, flags, frame_valid, frame_err, link_up);
    end
    push_good(12'h5A5, 12'h0A5, 8'h42);
    send_frame(8'h05, 8'hA5, 8'h00, 8'hA5, 8'h42,
               calc_chk(8'h05, 8'hA5, 8'h00, 8'hA5, 8'h42), 1);
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rst_mid missing event exp=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL rst_mid event got=%h exp=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid extra events got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (link_up !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_link got=%b exp=1", link_up);
    end
  endtask

  initial begin
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_frames();
    test_timeout();
    test_garbage_and_b2b();
    test_link_timeout();
    test_rst_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
